// File: rtl/loop_addr_gen.sv
// loop_addr_gen: row-major 2-D byte-address sequencer with valid/ready output and done pulse
module loop_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int ELEM_BYTES = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseAddrIn,
  input  logic [CNT_WIDTH-1:0]  numRowsIn,
  input  logic [CNT_WIDTH-1:0]  numColsIn,
  input  logic [ADDR_WIDTH-1:0] rowStrideIn,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  addrValidOut,
  input  logic                  addrReadyIn,
  output logic                  lastOut,
  output logic                  busyOut,
  output logic                  doneOut
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] row, col, lastRow, lastCol, rowNext, colNext;
  logic [ADDR_WIDTH-1:0] rowBase, rowStride, nextRowBase;
  logic handshake, zeroCmd;
  assign rowNext = row + CNT_WIDTH'(1);
  assign colNext = col + CNT_WIDTH'(1);
  assign nextRowBase = rowBase + rowStride;
  assign handshake = addrValidOut && addrReadyIn;
  assign zeroCmd = (numRowsIn == '0) || (numColsIn == '0);
  assign busyOut = state != IDLE;
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      lastRow      <= '0;
      lastCol      <= '0;
      rowBase      <= '0;
      rowStride    <= '0;
      addrOut      <= '0;
      addrValidOut <= 1'b0;
      lastOut      <= 1'b0;
      doneOut      <= 1'b0;
    end else begin
      doneOut <= 1'b0;
      case (state)
        IDLE: if (startIn) begin
          lastRow      <= numRowsIn - CNT_WIDTH'(1);
          lastCol      <= numColsIn - CNT_WIDTH'(1);
          rowStride    <= rowStrideIn;
          rowBase      <= baseAddrIn;
          addrOut      <= baseAddrIn;
          row          <= '0;
          col          <= '0;
          state        <= zeroCmd ? DONE : RUN;
          doneOut      <= zeroCmd;
          addrValidOut <= !zeroCmd;
          lastOut      <= (numRowsIn == CNT_WIDTH'(1)) && (numColsIn == CNT_WIDTH'(1));
        end
        RUN: if (handshake) begin
          if (col != lastCol) begin
            col     <= colNext;
            addrOut <= addrOut + ADDR_WIDTH'(ELEM_BYTES);
            lastOut <= (row == lastRow) && (colNext == lastCol);
          end else if (row != lastRow) begin
            col     <= '0;
            row     <= rowNext;
            rowBase <= nextRowBase;
            addrOut <= nextRowBase;
            lastOut <= (rowNext == lastRow) && (lastCol == '0);
          end else begin
            addrValidOut <= 1'b0;
            lastOut      <= 1'b0;
            doneOut      <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
